// File: rtl/sd_cmd_serial_card.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, checks them, and
// serializes short (48-bit) or long (136-bit) responses with a generated CRC7.

module sd_crc_7 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);
  logic [6:0] crc_q, crc_d, base;
  logic       fb;

  // Clear and enable together restart the CRC with the current bit as the first bit.
  always_comb begin
    base  = clr_i ? 7'd0 : crc_q;
    fb    = bit_i ^ base[6];
    crc_d = base;
    if (en_i) crc_d = {base[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) crc_q <= 7'd0;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;
endmodule

module sd_cmd_serial_card #(
  parameter int NCR_CYC   = 2,
  parameter bit CRC_CHECK = 1'b1
) (
  input  logic         SD_CLK_IN,
  input  logic         RST_IN,
  input  logic         cmd_dat_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  output logic         CMD_VALID_OUT,
  output logic [5:0]   CMD_IDX_OUT,
  output logic [31:0]  CMD_ARG_OUT,
  output logic         CRC_OK_OUT,
  input  logic         RSP_REQ_IN,
  input  logic [1:0]   RSP_TYPE_IN,
  input  logic [127:0] RSP_DATA_IN,
  output logic         RSP_ACK_OUT,
  output logic         BUSY_OUT,
  output logic [2:0]   state_o
);
  typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_WAIT, S_TX, S_ACK} state_t;

  localparam logic [5:0] NCR_LIM = 6'(NCR_CYC);

  state_t        state_q, state_d;
  logic [45:0]   rx_sr_q, rx_sr_d;
  logic [5:0]    rx_cnt_q, rx_cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic          crc_ok_q, crc_ok_d;
  logic [5:0]    ncr_q, ncr_d;
  logic          long_q, long_d;
  logic [127:0]  tx_sr_q, tx_sr_d;
  logic [7:0]    tx_cnt_q, tx_cnt_d;

  logic          rx_crc_clr, rx_crc_en, tx_crc_clr, tx_crc_en;
  logic [6:0]    rx_crc, tx_crc;
  logic [46:0]   frame;
  logic          rsp_kind;
  logic [7:0]    tx_pay, tx_last;
  logic [2:0]    crc_sel;

  sd_crc_7 u_rx_crc (
    .clk_i (SD_CLK_IN),
    .rst_i (RST_IN),
    .clr_i (rx_crc_clr),
    .en_i  (rx_crc_en),
    .bit_i (cmd_dat_i),
    .crc_o (rx_crc)
  );

  sd_crc_7 u_tx_crc (
    .clk_i (SD_CLK_IN),
    .rst_i (RST_IN),
    .clr_i (tx_crc_clr),
    .en_i  (tx_crc_en),
    .bit_i (tx_sr_q[127]),
    .crc_o (tx_crc)
  );

  // frame[46:0] is command bits 46..0 on the end-bit edge (bit 47 was the start bit).
  assign frame    = {rx_sr_q, cmd_dat_i};
  assign rsp_kind = (RSP_TYPE_IN == 2'b01) || (RSP_TYPE_IN == 2'b10);
  assign tx_pay   = long_q ? 8'd128 : 8'd40;
  assign tx_last  = long_q ? 8'd135 : 8'd47;
  assign crc_sel  = 3'(tx_cnt_q - tx_pay);

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q  <= S_IDLE;
      rx_sr_q  <= '0;
      rx_cnt_q <= '0;
      idx_q    <= '0;
      arg_q    <= '0;
      crc_ok_q <= 1'b0;
      ncr_q    <= '0;
      long_q   <= 1'b0;
      tx_sr_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rx_sr_q  <= rx_sr_d;
      rx_cnt_q <= rx_cnt_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      crc_ok_q <= crc_ok_d;
      ncr_q    <= ncr_d;
      long_q   <= long_d;
      tx_sr_q  <= tx_sr_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // Handshake: RSP_REQ_IN is a level the core holds until the single-cycle RSP_ACK_OUT;
  // type and data are captured once, on the edge that moves WAIT_RSP to TX.
  always_comb begin
    state_d    = state_q;
    rx_sr_d    = rx_sr_q;
    rx_cnt_d   = rx_cnt_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    crc_ok_d   = crc_ok_q;
    ncr_d      = ncr_q;
    long_d     = long_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
    rx_crc_clr = 1'b0;
    rx_crc_en  = 1'b0;
    tx_crc_clr = 1'b0;
    tx_crc_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_dat_i) begin
          state_d    = S_RX;
          rx_cnt_d   = 6'd1;
          rx_sr_d    = {rx_sr_q[44:0], cmd_dat_i};
          rx_crc_clr = 1'b1;
          rx_crc_en  = 1'b1;
        end
      end
      S_RX: begin
        rx_sr_d   = {rx_sr_q[44:0], cmd_dat_i};
        rx_cnt_d  = rx_cnt_q + 6'd1;
        rx_crc_en = (rx_cnt_q < 6'd40);
        if (rx_cnt_q == 6'd47) begin
          state_d  = S_CHECK;
          idx_d    = frame[45:40];
          arg_d    = frame[39:8];
          crc_ok_d = frame[46] & frame[0] & (!CRC_CHECK || (rx_crc == frame[7:1]));
          ncr_d    = 6'd1;
        end
      end
      S_CHECK: begin
        ncr_d   = ncr_q + 6'd1;
        state_d = crc_ok_q ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        ncr_d = (ncr_q == 6'd63) ? ncr_q : ncr_q + 6'd1;
        if (RSP_REQ_IN && !rsp_kind) begin
          state_d = S_ACK;
        end else if (RSP_REQ_IN) begin
          if (ncr_q >= NCR_LIM) begin
            state_d    = S_TX;
            long_d     = (RSP_TYPE_IN == 2'b10);
            tx_sr_d    = (RSP_TYPE_IN == 2'b10) ? {8'h3F, RSP_DATA_IN[127:8]}
                                                : {2'b00, RSP_DATA_IN[37:0], 88'd0};
            tx_cnt_d   = 8'd0;
            tx_crc_clr = 1'b1;
          end
        end else if (!cmd_dat_i) begin
          state_d    = S_RX;
          rx_cnt_d   = 6'd1;
          rx_sr_d    = {rx_sr_q[44:0], cmd_dat_i};
          rx_crc_clr = 1'b1;
          rx_crc_en  = 1'b1;
        end
      end
      S_TX: begin
        tx_cnt_d = tx_cnt_q + 8'd1;
        if (tx_cnt_q < tx_pay) begin
          tx_sr_d   = {tx_sr_q[126:0], 1'b0};
          // Long-response CRC covers only the body, not the start/tx/reserved bits.
          tx_crc_en = long_q ? (tx_cnt_q >= 8'd8) : 1'b1;
        end
        if (tx_cnt_q == tx_last) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_oe_o  = 1'b0;
    cmd_out_o = 1'b1;
    if (state_q == S_TX) begin
      cmd_oe_o = 1'b1;
      if (tx_cnt_q < tx_pay)              cmd_out_o = tx_sr_q[127];
      else if (tx_cnt_q < tx_pay + 8'd7)  cmd_out_o = tx_crc[3'd6 - crc_sel];
    end
  end

  assign CMD_VALID_OUT = (state_q == S_CHECK);
  assign RSP_ACK_OUT   = (state_q == S_ACK);
  assign BUSY_OUT      = (state_q != S_IDLE);
  assign CMD_IDX_OUT   = idx_q;
  assign CMD_ARG_OUT   = arg_q;
  assign CRC_OK_OUT    = crc_ok_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_sd_cmd_serial_card.sv
// Bench for sd_cmd_serial_card: table of command frames with expected decode and
// response, plus directed sequences for late requests, abort and mid-response reset.

module tb_sd_cmd_serial_card;
  localparam int NCR = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_dat = 1'b1;
  logic         req = 1'b0;
  logic [1:0]   rtype = 2'b00;
  logic [127:0] rdata = '0;

  logic         cmd_out, cmd_oe, valid, crc_ok, ack, busy;
  logic [5:0]   idx;
  logic [31:0]  arg;
  logic [2:0]   state;
  logic         nc_out, nc_oe, nc_valid, nc_crc_ok, nc_ack, nc_busy;
  logic [5:0]   nc_idx;
  logic [31:0]  nc_arg;
  logic [2:0]   nc_state;

  always #5 clk = ~clk;

  sd_cmd_serial_card #(.NCR_CYC(NCR), .CRC_CHECK(1'b1)) u_dut (
    .SD_CLK_IN(clk), .RST_IN(rst), .cmd_dat_i(cmd_dat),
    .cmd_out_o(cmd_out), .cmd_oe_o(cmd_oe), .CMD_VALID_OUT(valid),
    .CMD_IDX_OUT(idx), .CMD_ARG_OUT(arg), .CRC_OK_OUT(crc_ok),
    .RSP_REQ_IN(req), .RSP_TYPE_IN(rtype), .RSP_DATA_IN(rdata),
    .RSP_ACK_OUT(ack), .BUSY_OUT(busy), .state_o(state)
  );

  sd_cmd_serial_card #(.NCR_CYC(NCR), .CRC_CHECK(1'b0)) u_dut_nc (
    .SD_CLK_IN(clk), .RST_IN(rst), .cmd_dat_i(cmd_dat),
    .cmd_out_o(nc_out), .cmd_oe_o(nc_oe), .CMD_VALID_OUT(nc_valid),
    .CMD_IDX_OUT(nc_idx), .CMD_ARG_OUT(nc_arg), .CRC_OK_OUT(nc_crc_ok),
    .RSP_REQ_IN(req), .RSP_TYPE_IN(rtype), .RSP_DATA_IN(rdata),
    .RSP_ACK_OUT(nc_ack), .BUSY_OUT(nc_busy), .state_o(nc_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [127:0] d, input int n);
    logic [6:0] c;
    logic fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] i, input logic [31:0] a);
    logic [127:0] x;
    x = {88'd0, 2'b01, i, a};
    return {2'b01, i, a, crc7(x, 40), 1'b1};
  endfunction

  function automatic logic [135:0] exp_rsp(input logic [1:0] t, input logic [127:0] d);
    logic [127:0] x;
    if (t == 2'b10) begin
      x = {8'd0, d[127:8]};
      return {2'b00, 6'h3F, d[127:8], crc7(x, 120), 1'b1};
    end
    x = {88'd0, 2'b00, d[37:0]};
    return {88'd0, 2'b00, d[37:0], crc7(x, 40), 1'b1};
  endfunction

  // Line monitor: cycle stamps, VALID captures, ACK count and the current oe burst.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           valid_cnt = 0, valid_cyc = 0, ack_cnt = 0;
  int           burst_cnt = 0, burst_len = 0, burst_start = 0;
  logic [5:0]   v_idx = '0;
  logic [31:0]  v_arg = '0;
  logic         v_ok = 1'b0, nc_v_ok = 1'b0, prev_oe = 1'b0;
  logic [135:0] rsp_bits = '0;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      v_idx = idx;
      v_arg = arg;
      v_ok = crc_ok;
    end
    if (nc_valid) nc_v_ok = nc_crc_ok;
    if (ack) ack_cnt++;
    if (cmd_oe) begin
      if (!prev_oe) begin
        burst_cnt++;
        burst_len = 0;
        burst_start = cyc;
        rsp_bits = '0;
      end
      rsp_bits = {rsp_bits[134:0], cmd_out};
      burst_len++;
    end
    prev_oe = cmd_oe;
  end

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_dat = f[i];
    end
    @(negedge clk);
    cmd_dat = 1'b1;
  endtask

  task automatic wait_ack(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [47:0]  frame;
    logic [1:0]   rtype;
    logic [127:0] rdata;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         ok;
    logic         nc_ok;
    int           len;
    logic         ack;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int n);
    int vc0, ac0, bc0;
    bit got;
    string tag;
    tag = $sformatf("v%0d", n);
    @(posedge clk);
    vc0 = valid_cnt; ac0 = ack_cnt; bc0 = burst_cnt;
    @(negedge clk);
    rtype = v.rtype; rdata = v.rdata; req = 1'b1;
    send_cmd(v.frame);
    if (v.ack) begin
      wait_ack(400, got);
      chk({tag, "_ack_seen"}, got, 1);
    end else begin
      repeat (200) @(negedge clk);
    end
    req = 1'b0;
    repeat (3) @(posedge clk);
    chk({tag, "_valid_cnt"}, valid_cnt - vc0, 1);
    chk({tag, "_idx"}, v_idx, v.idx);
    chk({tag, "_arg"}, v_arg, v.arg);
    chk({tag, "_crc_ok"}, v_ok, v.ok);
    chk({tag, "_nc_crc_ok"}, nc_v_ok, v.nc_ok);
    chk({tag, "_ack_cnt"}, ack_cnt - ac0, v.ack);
    chk({tag, "_bursts"}, burst_cnt - bc0, (v.len != 0));
    if (v.len != 0) begin
      chk({tag, "_oe_len"}, burst_len, v.len);
      chk({tag, "_rsp_frame"}, rsp_bits, exp_rsp(v.rtype, v.rdata));
      chk({tag, "_ncr_gap"}, burst_start - valid_cyc, NCR);
      if (v.len == 136) chk({tag, "_long_ones"}, rsp_bits[133:128], 6'h3F);
    end
  endtask

  initial begin
    int   bc0, ac0, vc0, c_req;
    bit   got;
    logic [127:0] body_d;

    body_d = {120'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 8'h00};
    vecs[0] = '{48'h400000000095, 2'b01, 128'd0, 6'd0, 32'd0, 1'b1, 1'b1, 48, 1'b1};
    vecs[1] = '{48'h48000001AA87, 2'b10, body_d, 6'd8, 32'h1AA, 1'b1, 1'b1, 136, 1'b1};
    vecs[2] = '{48'h48000001AA89, 2'b01, 128'd0, 6'd8, 32'h1AA, 1'b0, 1'b1, 0, 1'b0};
    vecs[3] = '{48'h48000001AA86, 2'b01, 128'd0, 6'd8, 32'h1AA, 1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{mk_cmd(6'd17, 32'h12345678), 2'b01, {90'd0, 6'd17, 32'h00000900},
                6'd17, 32'h12345678, 1'b1, 1'b1, 48, 1'b1};
    vecs[5] = '{mk_cmd(6'd55, 32'hABCD0000), 2'b11, 128'd0, 6'd55, 32'hABCD0000,
                1'b1, 1'b1, 0, 1'b1};
    vecs[6] = '{mk_cmd(6'd2, 32'h0) & ~(48'h1 << 46), 2'b01, 128'd0, 6'd2, 32'h0,
                1'b0, 1'b0, 0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_oe", cmd_oe, 0);
    chk("rst_out", cmd_out, 1);
    chk("rst_valid", valid, 0);
    chk("rst_idx_arg_ok", {idx, arg, crc_ok}, 0);
    chk("rst_ack_busy", {ack, busy}, 0);
    chk("rst_state", state, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) chk("cmd0_rsp_hand", rsp_bits, 136'h000000000001);
    end

    // Late short request; data changed after latch must not alter the frame.
    @(posedge clk);
    bc0 = burst_cnt; ac0 = ack_cnt;
    @(negedge clk);
    req = 1'b0;
    send_cmd(mk_cmd(6'd13, 32'h0));
    repeat (10) @(negedge clk);
    rtype = 2'b01;
    rdata = {90'd0, 6'd13, 32'h00C0FFEE};
    req = 1'b1;
    c_req = cyc;
    @(negedge clk);
    rdata = {128{1'b1}};
    wait_ack(400, got);
    req = 1'b0;
    repeat (3) @(posedge clk);
    chk("late_ack_seen", got, 1);
    chk("late_bursts", burst_cnt - bc0, 1);
    chk("late_tx_start", burst_start, c_req + 1);
    chk("late_oe_len", burst_len, 48);
    chk("late_rsp_frame", rsp_bits, exp_rsp(2'b01, {90'd0, 6'd13, 32'h00C0FFEE}));

    // Late request of type none: acknowledged without driving the line.
    @(posedge clk);
    bc0 = burst_cnt; ac0 = ack_cnt;
    @(negedge clk);
    send_cmd(mk_cmd(6'd7, 32'h0));
    repeat (10) @(negedge clk);
    rtype = 2'b00;
    req = 1'b1;
    wait_ack(50, got);
    req = 1'b0;
    repeat (3) @(posedge clk);
    chk("none_ack_seen", got, 1);
    chk("none_ack_cnt", ack_cnt - ac0, 1);
    chk("none_bursts", burst_cnt - bc0, 0);

    // New command while waiting for a request aborts the first one.
    @(posedge clk);
    bc0 = burst_cnt; ac0 = ack_cnt; vc0 = valid_cnt;
    @(negedge clk);
    send_cmd(mk_cmd(6'd8, 32'h1AA));
    repeat (3) @(negedge clk);
    send_cmd(48'h400000000095);
    repeat (20) @(negedge clk);
    chk("abort_valid_cnt", valid_cnt - vc0, 2);
    chk("abort_idx", v_idx, 0);
    chk("abort_crc_ok", v_ok, 1);
    chk("abort_bursts", burst_cnt - bc0, 0);
    chk("abort_ack_cnt", ack_cnt - ac0, 0);
    rtype = 2'b00;
    req = 1'b1;
    wait_ack(50, got);
    req = 1'b0;
    chk("abort_release_ack", got, 1);

    // Reset at bit 20 of a long response releases the line immediately.
    repeat (3) @(negedge clk);
    rtype = 2'b10;
    rdata = body_d;
    req = 1'b1;
    send_cmd(48'h400000000095);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_oe) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rstmid_oe_seen", got, 1);
    repeat (20) @(negedge clk);
    chk("rstmid_pre_oe", cmd_oe, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_oe", cmd_oe, 0);
    chk("rstmid_out", cmd_out, 1);
    chk("rstmid_busy_ack", {busy, ack}, 0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_vec(vecs[0], 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d checks=%0d failures=%0d", cyc, checks, failures);
    $fatal(1);
  end
endmodule
